// File: rtl/boxcar_gate_averager_if.sv
// Sample, trigger, control and result bundle for the boxcar gate averager.
// master = the block that feeds samples and control words and reads results.
// slave  = the averager itself.
interface boxcar_gate_averager_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] din;
  logic                     trig_in;
  logic                     ctrl_enable;
  logic                     ctrl_trig_src;
  logic signed [DATA_W-1:0] ctrl_trig_level;
  logic [15:0]              ctrl_delay;
  logic [3:0]               ctrl_gate_log2;
  logic [15:0]              ctrl_holdoff;
  logic signed [DATA_W-1:0] dout;
  logic                     dout_valid;
  logic                     busy;
  logic [31:0]              trig_count;
  logic [15:0]              missed_count;

  modport master (
    output din, trig_in, ctrl_enable, ctrl_trig_src, ctrl_trig_level,
           ctrl_delay, ctrl_gate_log2, ctrl_holdoff,
    input  dout, dout_valid, busy, trig_count, missed_count
  );

  modport slave (
    input  din, trig_in, ctrl_enable, ctrl_trig_src, ctrl_trig_level,
           ctrl_delay, ctrl_gate_log2, ctrl_holdoff,
    output dout, dout_valid, busy, trig_count, missed_count
  );
endinterface

// File: rtl/boxcar_gate_averager.sv
// Triggered boxcar averager: on an accepted trigger, wait D cycles, sum 2^k
// consecutive samples and emit the floor average (arithmetic shift by k).
// After each result the trigger is held off for H cycles.
module boxcar_gate_averager #(
  parameter int DATA_W        = 16,
  parameter int GATE_LOG2_MAX = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  boxcar_gate_averager_if.slave bus
);
  localparam int         ACC_W = DATA_W + GATE_LOG2_MAX;
  localparam logic [3:0] K_MAX = 4'(GATE_LOG2_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELAY   = 2'd1,
    S_GATE    = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Trigger detection history
  logic                     trig_d_reg;
  logic                     din_prev_valid_reg;
  logic signed [DATA_W-1:0] din_prev_reg;

  // Acquisition parameters latched at the accepted trigger
  logic [3:0]               k_reg;
  logic [15:0]              holdoff_reg;

  // Shared down-counter for DELAY and HOLDOFF, sample counter for GATE
  logic [15:0]              cnt_reg;
  logic [GATE_LOG2_MAX-1:0] gate_cnt_reg;
  logic signed [ACC_W-1:0]  acc_reg;

  logic signed [DATA_W-1:0] dout_reg;
  logic                     dout_valid_reg;
  logic [31:0]              trig_count_reg;
  logic [15:0]              missed_count_reg;

  // Combinational helpers
  logic                     edge_event, cross_event, trig_event;
  logic                     accept, miss;
  logic                     busy, gate_step, gate_done;
  logic [3:0]               k_clamped;
  logic [GATE_LOG2_MAX-1:0] gate_last;
  logic signed [ACC_W-1:0]  din_ext, sum_next, avg_full;

  assign edge_event  = bus.trig_in & ~trig_d_reg;
  assign cross_event = din_prev_valid_reg
                     && (din_prev_reg < bus.ctrl_trig_level)
                     && (bus.din >= bus.ctrl_trig_level);
  assign trig_event  = bus.ctrl_trig_src ? cross_event : edge_event;
  assign accept      = bus.ctrl_enable && trig_event && (state_reg == S_IDLE);
  assign miss        = bus.ctrl_enable && trig_event && (state_reg != S_IDLE);

  assign k_clamped = (bus.ctrl_gate_log2 > K_MAX) ? K_MAX : bus.ctrl_gate_log2;
  // Low k bits set: index of the final sample in the gate (k=MAX gives all ones)
  assign gate_last = ~({GATE_LOG2_MAX{1'b1}} << k_reg);

  assign din_ext  = {{GATE_LOG2_MAX{bus.din[DATA_W-1]}}, bus.din};
  assign sum_next = acc_reg + din_ext;
  assign avg_full = sum_next >>> k_reg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; dropping enable overrides everything
  always_comb begin
    state_next = state_reg;
    if (!bus.ctrl_enable) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:    if (trig_event)
                     state_next = (bus.ctrl_delay != 16'd0) ? S_DELAY : S_GATE;
        S_DELAY:   if (cnt_reg == 16'd1) state_next = S_GATE;
        S_GATE:    if (gate_done)
                     state_next = (holdoff_reg != 16'd0) ? S_HOLDOFF : S_IDLE;
        S_HOLDOFF: if (cnt_reg == 16'd1) state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs and gate strobes
  always_comb begin
    busy      = (state_reg != S_IDLE);
    gate_step = bus.ctrl_enable && (state_reg == S_GATE);
    gate_done = gate_step && (gate_cnt_reg == gate_last);
  end

  // Trigger history; trig_d starts high so a level held through reset is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_d_reg         <= 1'b1;
      din_prev_valid_reg <= 1'b0;
      din_prev_reg       <= '0;
    end else begin
      trig_d_reg         <= bus.trig_in;
      din_prev_valid_reg <= 1'b1;
      din_prev_reg       <= bus.din;
    end
  end

  // Latch acquisition parameters and run the delay/holdoff/gate counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_reg        <= '0;
      holdoff_reg  <= '0;
      cnt_reg      <= '0;
      gate_cnt_reg <= '0;
    end else if (accept) begin
      k_reg        <= k_clamped;
      holdoff_reg  <= bus.ctrl_holdoff;
      cnt_reg      <= bus.ctrl_delay;
      gate_cnt_reg <= '0;
    end else if (gate_done) begin
      cnt_reg      <= holdoff_reg;
    end else if (gate_step) begin
      gate_cnt_reg <= gate_cnt_reg + 1'b1;
    end else if (bus.ctrl_enable && (state_reg == S_DELAY || state_reg == S_HOLDOFF)) begin
      cnt_reg      <= cnt_reg - 16'd1;
    end
  end

  // Accumulator: cleared on accept, sums each gated sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         acc_reg <= '0;
    else if (accept)    acc_reg <= '0;
    else if (gate_step) acc_reg <= sum_next;
  end

  // Result register and one-cycle valid strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= gate_done;
      if (gate_done) dout_reg <= avg_full[DATA_W-1:0];
    end
  end

  // Status counters: accepted triggers wrap, missed triggers saturate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_count_reg   <= '0;
      missed_count_reg <= '0;
    end else begin
      if (accept) trig_count_reg <= trig_count_reg + 32'd1;
      if (miss && missed_count_reg != 16'hFFFF)
        missed_count_reg <= missed_count_reg + 16'd1;
    end
  end

  assign bus.dout         = dout_reg;
  assign bus.dout_valid   = dout_valid_reg;
  assign bus.busy         = busy;
  assign bus.trig_count   = trig_count_reg;
  assign bus.missed_count = missed_count_reg;
endmodule

// File: tb/tb_boxcar_gate_averager.sv
// Directed bench for boxcar_gate_averager. Inputs change and outputs are
// sampled on the falling edge; index i in run_acq means "after edge E0+i".
module tb_boxcar_gate_averager;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  boxcar_gate_averager_if #(.DATA_W(16)) bus ();

  boxcar_gate_averager #(.DATA_W(16), .GATE_LOG2_MAX(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic signed [15:0] din_seq[$];

  // Default control words, reset pulse, one idle edge so trig_d clears
  task automatic apply_reset();
    bus.din = 16'sd0;  bus.trig_in = 1'b0;
    bus.ctrl_enable = 1'b1; bus.ctrl_trig_src = 1'b0; bus.ctrl_trig_level = 16'sd0;
    bus.ctrl_delay = 16'd0; bus.ctrl_gate_log2 = 4'd0; bus.ctrl_holdoff = 16'd0;
    din_seq.delete();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Trigger must already be set up for edge E0. Drops trig_in, feeds din_seq,
  // records first dout_valid index/value and number of valid cycles.
  task automatic run_acq(input int max_cycles, input bit stop_on_valid,
                         output int idx, output int nvalid, output logic signed [15:0] val);
    idx = -1; nvalid = 0; val = 16'sd0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      bus.trig_in = 1'b0;
      if (bus.dout_valid) begin
        if (nvalid == 0) begin idx = i; val = bus.dout; end
        nvalid++;
        if (stop_on_valid) break;
      end
      if (i < din_seq.size()) bus.din = din_seq[i];
    end
  endtask

  task automatic test_reset();
    bus.trig_in = 1'b0; bus.din = 16'sd0; reset = 1'b0;
    #1;
    tests_run++;
    if (bus.dout !== 16'sd0 || bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.trig_count !== 32'd0 || bus.missed_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: dout=%0d valid=%b busy=%b trig=%0d missed=%0d, want all 0",
               bus.dout, bus.dout_valid, bus.busy, bus.trig_count, bus.missed_count);
    end
    apply_reset();
    tests_run++;
    if (bus.busy !== 1'b0 || bus.trig_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b trig=%0d, want 0 0", bus.busy, bus.trig_count);
    end
    $display("[TB] test_reset done");
  endtask

  // D=0, k=2, din=1000: valid exactly once at E0+4, dout=1000
  task automatic test_basic();
    int idx, n; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_gate_log2 = 4'd2; bus.din = 16'sd1000; bus.trig_in = 1'b1;
    run_acq(12, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 4 || n !== 1) begin
      tests_failed++;
      $display("FAIL basic_timing: idx=%0d count=%0d, want idx=4 count=1", idx, n);
    end
    tests_run++;
    if (val !== 16'sd1000) begin
      tests_failed++; $display("FAIL basic_value: dout=%0d, want 1000", val);
    end
    tests_run++;
    if (bus.trig_count !== 32'd1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_status: trig=%0d busy=%b, want 1 0", bus.trig_count, bus.busy);
    end
    $display("[TB] test_basic idx=%0d val=%0d", idx, val);
  endtask

  // din = edge index n, trigger at n=10, D=3, k=2: samples 14..17, sum 62 -> 15
  task automatic test_delay_ramp();
    int idx, n; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_gate_log2 = 4'd2; bus.ctrl_delay = 16'd3;
    for (int j = 0; j < 20; j++) din_seq.push_back(16'(11 + j));
    bus.din = 16'sd10; bus.trig_in = 1'b1;
    run_acq(15, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 7 || n !== 1) begin
      tests_failed++;
      $display("FAIL ramp_timing: idx=%0d count=%0d, want idx=7 count=1", idx, n);
    end
    tests_run++;
    if (val !== 16'sd15) begin
      tests_failed++; $display("FAIL ramp_value: dout=%0d, want 15", val);
    end
    $display("[TB] test_delay_ramp idx=%0d val=%0d", idx, val);
  endtask

  // Level crossing at 0: -5,-5,+5 triggers once; D=2 holds +5,+5, then gated
  // samples -1,0 -> floor(-1/2) = -1. The -1 -> 0 step also crosses the
  // level during GATE, so it is counted as missed.
  task automatic test_level_cross();
    int idx, n; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_trig_src = 1'b1; bus.ctrl_gate_log2 = 4'd1; bus.ctrl_delay = 16'd2;
    bus.din = -16'sd5; @(negedge clk); @(negedge clk);
    din_seq = '{16'sd5, 16'sd5, -16'sd1, 16'sd0};
    bus.din = 16'sd5;
    run_acq(10, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 4 || n !== 1 || val !== -16'sd1) begin
      tests_failed++;
      $display("FAIL cross_result: idx=%0d count=%0d dout=%0d, want 4 1 -1", idx, n, val);
    end
    tests_run++;
    if (bus.trig_count !== 32'd1 || bus.missed_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL cross_counts: trig=%0d missed=%0d, want 1 1", bus.trig_count, bus.missed_count);
    end
    $display("[TB] test_level_cross idx=%0d val=%0d", idx, val);
  endtask

  // H=10: edge 3 after result is missed, edge 12 after is accepted
  task automatic test_holdoff();
    int idx, n, extra; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_gate_log2 = 4'd1; bus.ctrl_holdoff = 16'd10; bus.din = 16'sd100;
    bus.trig_in = 1'b1;
    run_acq(10, 1'b1, idx, n, val);
    tests_run++;
    if (idx !== 2 || val !== 16'sd100) begin
      tests_failed++; $display("FAIL holdoff_first: idx=%0d dout=%0d, want 2 100", idx, val);
    end
    extra = 0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (bus.dout_valid) extra++;
      if (j == 2) bus.trig_in = 1'b1;
      if (j == 3) bus.trig_in = 1'b0;
      if (j == 9) begin
        tests_run++;
        if (bus.busy !== 1'b1) begin
          tests_failed++; $display("FAIL holdoff_busy_end: busy=%b, want 1", bus.busy);
        end
      end
      if (j == 10) begin
        tests_run++;
        if (bus.busy !== 1'b0) begin
          tests_failed++; $display("FAIL holdoff_idle: busy=%b, want 0", bus.busy);
        end
      end
      if (j == 11) bus.trig_in = 1'b1;
    end
    tests_run++;
    if (extra !== 0 || bus.missed_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL holdoff_missed: extra_valid=%0d missed=%0d, want 0 1", extra, bus.missed_count);
    end
    run_acq(10, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 2 || n !== 1 || bus.trig_count !== 32'd2) begin
      tests_failed++;
      $display("FAIL holdoff_second: idx=%0d count=%0d trig=%0d, want 2 1 2", idx, n, bus.trig_count);
    end
    $display("[TB] test_holdoff missed=%0d trig=%0d", bus.missed_count, bus.trig_count);
  endtask

  // k=15 clamps to 12: 4096 full-scale samples, both polarities
  task automatic test_full_scale();
    int idx, n; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_gate_log2 = 4'd15; bus.din = -16'sd32768; bus.trig_in = 1'b1;
    run_acq(4100, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 4096 || n !== 1 || val !== -16'sd32768) begin
      tests_failed++;
      $display("FAIL full_neg: idx=%0d count=%0d dout=%0d, want 4096 1 -32768", idx, n, val);
    end
    bus.din = 16'sd32767; bus.trig_in = 1'b1;
    run_acq(4100, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 4096 || n !== 1 || val !== 16'sd32767) begin
      tests_failed++;
      $display("FAIL full_pos: idx=%0d count=%0d dout=%0d, want 4096 1 32767", idx, n, val);
    end
    $display("[TB] test_full_scale last=%0d", val);
  endtask

  // Reset mid-GATE with trig_in held high through release
  task automatic test_reset_mid_gate();
    int idx, n, bad; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_gate_log2 = 4'd3; bus.din = 16'sd500; bus.trig_in = 1'b1;
    run_acq(12, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 8 || val !== 16'sd500) begin
      tests_failed++; $display("FAIL rst_pre: idx=%0d dout=%0d, want 8 500", idx, val);
    end
    bus.trig_in = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bus.dout !== 16'sd0 || bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.trig_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_async: dout=%0d valid=%b busy=%b trig=%0d, want all 0",
               bus.dout, bus.dout_valid, bus.busy, bus.trig_count);
    end
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.trig_count !== 32'd0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL rst_held_trig: bad_cycles=%0d, want 0", bad);
    end
    bus.trig_in = 1'b0; @(negedge clk);
    bus.trig_in = 1'b1;
    run_acq(12, 1'b0, idx, n, val);
    tests_run++;
    if (idx !== 8 || n !== 1 || bus.trig_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL rst_retrig: idx=%0d count=%0d trig=%0d, want 8 1 1", idx, n, bus.trig_count);
    end
    $display("[TB] test_reset_mid_gate idx=%0d", idx);
  endtask

  // Dropping enable mid-GATE discards the acquisition
  task automatic test_enable_abort();
    int idx, n, vcount; logic signed [15:0] val;
    apply_reset();
    bus.ctrl_gate_log2 = 4'd3; bus.din = 16'sd500; bus.trig_in = 1'b1;
    run_acq(12, 1'b0, idx, n, val);
    bus.din = 16'sd700; bus.trig_in = 1'b1;
    @(negedge clk); bus.trig_in = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.ctrl_enable = 1'b0;
    vcount = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (bus.dout_valid) vcount++;
      if (j == 0) begin
        tests_run++;
        if (bus.busy !== 1'b0) begin
          tests_failed++; $display("FAIL abort_idle: busy=%b, want 0", bus.busy);
        end
      end
      if (j == 2) bus.trig_in = 1'b1;
      if (j == 3) bus.trig_in = 1'b0;
    end
    tests_run++;
    if (vcount !== 0 || bus.dout !== 16'sd500) begin
      tests_failed++;
      $display("FAIL abort_output: valid_cycles=%0d dout=%0d, want 0 500", vcount, bus.dout);
    end
    tests_run++;
    if (bus.trig_count !== 32'd2 || bus.missed_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL abort_counts: trig=%0d missed=%0d, want 2 0", bus.trig_count, bus.missed_count);
    end
    $display("[TB] test_enable_abort dout=%0d", bus.dout);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_ramp();
    test_level_cross();
    test_holdoff();
    test_full_scale();
    test_reset_mid_gate();
    test_enable_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
